// File: rtl/matmul_input_control.sv
// Streams a latched DEPTH x ROWS matrix into a systolic array, one lane per row,
// staggered one cycle per lane, with each element held for HOLD cycles.
module matmul_input_control #(
   parameter int WORD_SIZE = 16,
   parameter int ROWS      = 4,
   parameter int DEPTH     = 4,
   parameter int HOLD      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      en,
   input  logic [WORD_SIZE-1:0]      input_matrix [DEPTH][ROWS],
   output logic [ROWS*WORD_SIZE-1:0] matmul_fsm_input,
   output logic [ROWS-1:0]           input_valid,
   output logic                      busy,
   output logic                      done
);

   localparam int SPAN   = DEPTH * HOLD;
   localparam int T_LAST = (ROWS - 1) + SPAN - 1;
   localparam int TW     = (T_LAST < 1) ? 1 : $clog2(T_LAST + 1);
   localparam logic [TW-1:0] T_LAST_C = TW'(T_LAST);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                     state_r, state_nxt_s;
   logic [TW-1:0]              t_r, t_nxt_s;
   logic [WORD_SIZE-1:0]       mat_r [DEPTH][ROWS];
   logic [ROWS*WORD_SIZE-1:0]  data_r, lane_data_s;
   logic [ROWS-1:0]            valid_r, lane_valid_s;
   logic                       busy_r, done_r, ready_r;
   logic                       load_s, upd_s, clr_s;

   // Release guard: blocks start on the first edge after reset deassertion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ready_r <= 1'b0;
      else      ready_r <= 1'b1;
   end

   // State and stream counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         t_r     <= '0;
      end else begin
         state_r <= state_nxt_s;
         t_r     <= t_nxt_s;
      end
   end

   // Next-state logic and lane update strobes
   always_comb begin
      state_nxt_s = state_r;
      t_nxt_s     = t_r;
      load_s      = 1'b0;
      upd_s       = 1'b0;
      clr_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && ready_r) begin
               state_nxt_s = ST_STREAM;
               t_nxt_s     = '0;
               load_s      = 1'b1;
               upd_s       = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (en) begin
               if (t_r == T_LAST_C) begin
                  state_nxt_s = ST_DONE;
                  t_nxt_s     = '0;
                  clr_s       = 1'b1;
               end else begin
                  t_nxt_s = t_r + TW'(1);
                  upd_s   = 1'b1;
               end
            end else begin
               state_nxt_s = ST_STREAM;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            t_nxt_s     = '0;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            t_nxt_s     = '0;
            clr_s       = 1'b1;
         end
      endcase
   end

   // Lane contents for the upcoming count; the start edge reads the live matrix
   always_comb begin
      int rel;
      lane_data_s  = '0;
      lane_valid_s = '0;
      rel          = 0;
      for (int r = 0; r < ROWS; r++) begin
         rel = int'(t_nxt_s) - r;
         if (rel >= 0 && rel < SPAN) begin
            lane_valid_s[r] = 1'b1;
            if (load_s) begin
               lane_data_s[r*WORD_SIZE +: WORD_SIZE] = input_matrix[rel / HOLD][r];
            end else begin
               lane_data_s[r*WORD_SIZE +: WORD_SIZE] = mat_r[rel / HOLD][r];
            end
         end else begin
            lane_valid_s[r] = 1'b0;
         end
      end
   end

   // Matrix snapshot taken on the start edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            for (int r = 0; r < ROWS; r++) begin
               mat_r[k][r] <= '0;
            end
         end
      end else if (load_s) begin
         mat_r <= input_matrix;
      end
   end

   // Registered lane outputs and status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_r  <= '0;
         valid_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         if (upd_s) begin
            data_r  <= lane_data_s;
            valid_r <= lane_valid_s;
         end else if (clr_s) begin
            data_r  <= '0;
            valid_r <= '0;
         end
         busy_r <= (state_nxt_s == ST_STREAM);
         done_r <= (state_nxt_s == ST_DONE);
      end
   end

   assign matmul_fsm_input = data_r;
   assign input_valid      = valid_r;
   assign busy             = busy_r;
   assign done             = done_r;

endmodule
